// File: rtl/axil_acc_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite accelerator register file.
package axil_acc_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned IDX_CTRL   = 0;
  localparam int unsigned IDX_STATUS = 1;
  localparam int unsigned IDX_RESULT = 2;
  localparam int unsigned IDX_OPER0  = 3;

  localparam int unsigned BIT_START  = 0;
  localparam int unsigned BIT_IRQ_EN = 1;
  localparam int unsigned BIT_BUSY   = 0;
  localparam int unsigned BIT_DONE   = 1;

  typedef enum logic [1:0] {WIdle, WAck, WResp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RAck, RData} rd_state_e;

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite channel handshakes: independent write and read FSMs that present a
// one-cycle register-file write/read strobe with a decoded register index.
module axil_slave_if
  import axil_acc_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [AddrWidth-1:0]                       awaddr_i,
  input  logic                                       awvalid_i,
  output logic                                       awready_o,
  input  logic [DataWidth-1:0]                       wdata_i,
  input  logic [DataWidth/8-1:0]                     wstrb_i,
  input  logic                                       wvalid_i,
  output logic                                       wready_o,
  output logic [1:0]                                 bresp_o,
  output logic                                       bvalid_o,
  input  logic                                       bready_i,
  input  logic [AddrWidth-1:0]                       araddr_i,
  input  logic                                       arvalid_i,
  output logic                                       arready_o,
  output logic [DataWidth-1:0]                       rdata_o,
  output logic [1:0]                                 rresp_o,
  output logic                                       rvalid_o,
  input  logic                                       rready_i,
  output logic                                       wr_en_o,
  output logic [AddrWidth-$clog2(DataWidth/8)-1:0]   wr_idx_o,
  output logic [DataWidth-1:0]                       wr_data_o,
  output logic [DataWidth/8-1:0]                     wr_strb_o,
  output logic                                       rd_en_o,
  output logic [AddrWidth-$clog2(DataWidth/8)-1:0]   rd_idx_o,
  input  logic [DataWidth-1:0]                       rd_data_i,
  input  logic                                       wr_err_i,
  input  logic                                       rd_err_i
);

  localparam int unsigned OffWidth = $clog2(DataWidth/8);
  localparam int unsigned IdxWidth = AddrWidth - OffWidth;

  wr_state_e              wr_state_q;
  rd_state_e              rd_state_q;
  logic                   awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [IdxWidth-1:0]    wr_idx_q, rd_idx_q;
  logic [DataWidth-1:0]   wr_data_q, rdata_q;
  logic [DataWidth/8-1:0] wr_strb_q;

  // A lone AW or W is left waiting; both must be valid before accepting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      unique case (wr_state_q)
        WIdle: begin
          if (awvalid_i && wvalid_i) begin
            wr_state_q <= WAck;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_idx_q   <= awaddr_i[AddrWidth-1:OffWidth];
            wr_data_q  <= wdata_i;
            wr_strb_q  <= wstrb_i;
          end
        end
        WAck: begin
          wr_state_q <= WResp;
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b1;
          bresp_q    <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
        end
        WResp: begin
          if (bready_i) begin
            wr_state_q <= WIdle;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
          end
        end
        default: wr_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_idx_q   <= '0;
    end else begin
      unique case (rd_state_q)
        RIdle: begin
          if (arvalid_i) begin
            rd_state_q <= RAck;
            arready_q  <= 1'b1;
            rd_idx_q   <= araddr_i[AddrWidth-1:OffWidth];
          end
        end
        RAck: begin
          rd_state_q <= RData;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b1;
          rdata_q    <= rd_data_i;
          rresp_q    <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
        end
        RData: begin
          if (rready_i) begin
            rd_state_q <= RIdle;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
          end
        end
        default: rd_state_q <= RIdle;
      endcase
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rresp_o   = rresp_q;
  assign rdata_o   = rdata_q;

  assign wr_en_o   = (wr_state_q == WAck);
  assign wr_idx_o  = wr_idx_q;
  assign wr_data_o = wr_data_q;
  assign wr_strb_o = wr_strb_q;
  assign rd_en_o   = (rd_state_q == RAck);
  assign rd_idx_o  = rd_idx_q;

  logic unused_offset;
  assign unused_offset = ^{awaddr_i[OffWidth-1:0], araddr_i[OffWidth-1:0]};

endmodule

// File: rtl/axil_acc_regfile.sv
// AXI4-Lite register file fronting a single-launch accelerator: CTRL/STATUS,
// captured RESULT, operand registers, a START pulse and a DONE interrupt.
module axil_acc_regfile
  import axil_acc_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_REGS         = 8,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                                           S_AXI_ACLK,
  input  logic                                           S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                                     S_AXI_AWPROT,
  input  logic                                           S_AXI_AWVALID,
  output logic                                           S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  input  logic                                           S_AXI_WVALID,
  output logic                                           S_AXI_WREADY,
  output logic [1:0]                                     S_AXI_BRESP,
  output logic                                           S_AXI_BVALID,
  input  logic                                           S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                                     S_AXI_ARPROT,
  input  logic                                           S_AXI_ARVALID,
  output logic                                           S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                     S_AXI_RRESP,
  output logic                                           S_AXI_RVALID,
  input  logic                                           S_AXI_RREADY,
  output logic                                           usr_start,
  input  logic                                           usr_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  usr_result,
  output logic [(C_NUM_REGS-3)*C_S_AXI_DATA_WIDTH-1:0]   usr_regs,
  output logic                                           irq
);

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned StrbW   = DW / 8;
  localparam int unsigned OffW    = $clog2(StrbW);
  localparam int unsigned IdxW    = C_S_AXI_ADDR_WIDTH - OffW;
  localparam int unsigned NumOper = C_NUM_REGS - IDX_OPER0;
  localparam logic [IdxW:0] NumRegsCmp = (IdxW + 1)'(C_NUM_REGS);

  if (DW != 32 && DW != 64) begin : g_bad_data_width
    $error("C_S_AXI_DATA_WIDTH must be 32 or 64");
  end
  if (C_NUM_REGS < 4 || C_NUM_REGS > 64) begin : g_bad_num_regs
    $error("C_NUM_REGS must be in 4..64");
  end
  if (C_S_AXI_ADDR_WIDTH < $clog2(C_NUM_REGS) + OffW) begin : g_bad_addr_width
    $error("C_S_AXI_ADDR_WIDTH too small for C_NUM_REGS registers");
  end

  logic             wr_en, rd_en, wr_err, rd_err;
  logic [IdxW-1:0]  wr_idx, rd_idx;
  logic [DW-1:0]    wr_data, rd_data;
  logic [StrbW-1:0] wr_strb;

  axil_slave_if #(
    .DataWidth (DW),
    .AddrWidth (C_S_AXI_ADDR_WIDTH)
  ) u_slave_if (
    .clk_i     (S_AXI_ACLK),
    .rst_i     (S_AXI_ARESET),
    .awaddr_i  (S_AXI_AWADDR),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bresp_o   (S_AXI_BRESP),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .araddr_i  (S_AXI_ARADDR),
    .arvalid_i (S_AXI_ARVALID),
    .arready_o (S_AXI_ARREADY),
    .rdata_o   (S_AXI_RDATA),
    .rresp_o   (S_AXI_RRESP),
    .rvalid_o  (S_AXI_RVALID),
    .rready_i  (S_AXI_RREADY),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .rd_en_o   (rd_en),
    .rd_idx_o  (rd_idx),
    .rd_data_i (rd_data),
    .wr_err_i  (wr_err),
    .rd_err_i  (rd_err)
  );

  logic          irq_en_q, busy_q, done_q, start_q, irq_q;
  logic [DW-1:0] result_q;
  logic [DW-1:0] oper_q [NumOper];

  logic wr_hit, ctrl_wr, start_req, done_set, done_clr;

  assign wr_err    = ({1'b0, wr_idx} >= NumRegsCmp);
  assign rd_err    = ({1'b0, rd_idx} >= NumRegsCmp);
  assign wr_hit    = wr_en && !wr_err;
  assign ctrl_wr   = wr_hit && (wr_idx == IdxW'(IDX_CTRL)) && wr_strb[0];
  assign start_req = ctrl_wr && wr_data[BIT_START] && !busy_q;
  assign done_set  = usr_done && busy_q;
  assign done_clr  = wr_hit && (wr_idx == IdxW'(IDX_STATUS)) && wr_strb[0] && wr_data[BIT_DONE];

  // done_set needs BUSY=1 and start_req needs BUSY=0, so they never collide.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      result_q <= '0;
      for (int unsigned i = 0; i < NumOper; i++) begin
        oper_q[i] <= '0;
      end
    end else begin
      start_q <= start_req;
      irq_q   <= done_q && irq_en_q;
      if (ctrl_wr) begin
        irq_en_q <= wr_data[BIT_IRQ_EN];
      end
      if (done_set) begin
        busy_q <= 1'b0;
      end else if (start_req) begin
        busy_q <= 1'b1;
      end
      // A completion in the same cycle as a W1C keeps DONE set.
      if (done_set) begin
        done_q   <= 1'b1;
        result_q <= usr_result;
      end else if (done_clr) begin
        done_q <= 1'b0;
      end
      for (int unsigned i = 0; i < NumOper; i++) begin
        if (wr_hit && (wr_idx == IdxW'(i + IDX_OPER0))) begin
          for (int unsigned b = 0; b < StrbW; b++) begin
            if (wr_strb[b]) begin
              oper_q[i][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_idx == IdxW'(IDX_CTRL)) begin
      rd_data[BIT_IRQ_EN] = irq_en_q;
    end else if (rd_idx == IdxW'(IDX_STATUS)) begin
      rd_data[BIT_BUSY] = busy_q;
      rd_data[BIT_DONE] = done_q;
    end else if (rd_idx == IdxW'(IDX_RESULT)) begin
      rd_data = result_q;
    end
    for (int unsigned i = 0; i < NumOper; i++) begin
      if (rd_idx == IdxW'(i + IDX_OPER0)) begin
        rd_data = oper_q[i];
      end
    end
  end

  for (genvar g = 0; g < NumOper; g++) begin : g_usr_regs
    assign usr_regs[g*DW +: DW] = oper_q[g];
  end

  assign usr_start = start_q;
  assign irq       = irq_q;

  logic unused_sigs;
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, rd_en};

endmodule
